// File: rtl/dot11_tx_bit_encoder.sv
// dot11_tx_bit_encoder
//   Transmit bit pipeline for an OFDM PSDU: prepends the 16-bit SERVICE
//   field, scrambles (x^7+x^4+1), inserts 6 zero tail bits and scrambled
//   pad bits up to a whole number of OFDM symbols, then applies the K=7
//   rate-1/2 convolutional code (g0=133o -> A, g1=171o -> B).
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   start                       one-cycle pulse, only honoured in IDLE
//   pkt_len, n_dbps, scram_seed packet parameters, latched on start
//   byte_in/_valid/_ready       PSDU byte stream, LSB transmitted first
//   coded_out/_valid/_ready     coded pair {B,A} to the puncturer
//   busy, done, n_sym           status: active, end pulse, symbols emitted
module dot11_tx_bit_encoder #(
  parameter int LEN_W  = 12,
  parameter int DBPS_W = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DBPS_W-1:0] n_dbps,
  input  logic [6:0]        scram_seed,
  input  logic [7:0]        byte_in,
  input  logic              byte_in_valid,
  output logic              byte_in_ready,
  output logic [1:0]        coded_out,
  output logic              coded_out_valid,
  input  logic              coded_out_ready,
  output logic              busy,
  output logic              done,
  output logic [DBPS_W-1:0] n_sym
);

  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVICE = 3'd1,
    ST_DATA    = 3'd2,
    ST_TAIL    = 3'd3,
    ST_PAD     = 3'd4,
    ST_FLUSH   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DBPS_W-1:0] dbps_q, dbps_d;
  logic [6:0]        scr_q, scr_d;
  logic [5:0]        enc_q, enc_d;     // enc_q[0] = d1 ... enc_q[5] = d6
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // bit index within the current state
  logic [DBPS_W-1:0] sym_q, sym_d;
  logic [DBPS_W-1:0] nsym_q, nsym_d;
  logic [7:0]        byte_q, byte_d;
  logic [1:0]        pair_q, pair_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic out_free_s, run_s, src_ok_s, step_s;
  logic raw_s, fb_s, u_s, a_s, b_s;
  logic sym_last_s, data_last_s;

  // Step qualification, scrambler/encoder datapath for the current bit.
  always_comb begin
    out_free_s = !valid_q || coded_out_ready;
    case (state_q)
      ST_SERVICE, ST_DATA, ST_TAIL, ST_PAD: run_s = 1'b1;
      default:                              run_s = 1'b0;
    endcase
    // In DATA at bit 0 the bit comes straight from byte_in.
    if (state_q == ST_DATA && cnt_q[2:0] == 3'd0) begin
      src_ok_s = byte_in_valid;
      raw_s    = byte_in[0];
    end else if (state_q == ST_DATA) begin
      src_ok_s = 1'b1;
      raw_s    = byte_q[cnt_q[2:0]];
    end else begin
      src_ok_s = 1'b1;
      raw_s    = 1'b0;
    end
    step_s        = run_s && out_free_s && src_ok_s;
    byte_in_ready = (state_q == ST_DATA) && (cnt_q[2:0] == 3'd0) && out_free_s;
    fb_s = scr_q[6] ^ scr_q[3];
    // Tail bits still clock the scrambler but enter the encoder as zero.
    if (state_q == ST_TAIL) begin
      u_s = 1'b0;
    end else begin
      u_s = raw_s ^ fb_s;
    end
    a_s = u_s ^ enc_q[1] ^ enc_q[2] ^ enc_q[4] ^ enc_q[5];
    b_s = u_s ^ enc_q[0] ^ enc_q[1] ^ enc_q[2] ^ enc_q[5];
    sym_last_s  = (sym_q == (dbps_q - DBPS_W'(1)));
    data_last_s = (cnt_q == ({len_q, 3'b000} - CNT_W'(1)));
  end

  // Next-state logic: per-step datapath updates, then state sequencing.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dbps_d  = dbps_q;
    scr_d   = scr_q;
    enc_d   = enc_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    nsym_d  = nsym_q;
    byte_d  = byte_q;
    pair_d  = pair_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (step_s) begin
      scr_d   = {scr_q[5:0], fb_s};
      enc_d   = {enc_q[4:0], u_s};
      pair_d  = {b_s, a_s};
      valid_d = 1'b1;
      if (sym_last_s) begin
        sym_d  = {DBPS_W{1'b0}};
        nsym_d = nsym_q + DBPS_W'(1);
      end else begin
        sym_d  = sym_q + DBPS_W'(1);
        nsym_d = nsym_q;
      end
    end else if (coded_out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (step_s && state_q == ST_DATA && cnt_q[2:0] == 3'd0) begin
      byte_d = byte_in;
    end else begin
      byte_d = byte_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = pkt_len;
          dbps_d  = n_dbps;
          scr_d   = (scram_seed == 7'h00) ? 7'h7F : scram_seed;
          enc_d   = 6'd0;
          cnt_d   = {CNT_W{1'b0}};
          sym_d   = {DBPS_W{1'b0}};
          nsym_d  = {DBPS_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_SERVICE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (step_s && cnt_q == CNT_W'(15)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = (len_q != {LEN_W{1'b0}}) ? ST_DATA : ST_TAIL;
        end else if (step_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DATA: begin
        if (step_s && data_last_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_TAIL;
        end else if (step_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_TAIL: begin
        // The 6th tail bit may itself close the symbol; then no pad is needed.
        if (step_s && cnt_q == CNT_W'(5)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = sym_last_s ? ST_FLUSH : ST_PAD;
        end else if (step_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PAD: begin
        if (step_s && sym_last_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_FLUSH: begin
        if (out_free_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      len_q   <= {LEN_W{1'b0}};
      dbps_q  <= {DBPS_W{1'b0}};
      scr_q   <= 7'd0;
      enc_q   <= 6'd0;
      cnt_q   <= {CNT_W{1'b0}};
      sym_q   <= {DBPS_W{1'b0}};
      nsym_q  <= {DBPS_W{1'b0}};
      byte_q  <= 8'd0;
      pair_q  <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dbps_q  <= dbps_d;
      scr_q   <= scr_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      nsym_q  <= nsym_d;
      byte_q  <= byte_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign coded_out       = pair_q;
  assign coded_out_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign n_sym           = nsym_q;

endmodule
